// File: rtl/fifo_read_control.sv
// Purpose : read-side controller of a synchronous FIFO; gates pop against empty,
//           owns the read pointer, and derives empty/almost_empty/level from wr_ptr.
// Latency : rd_en is combinational; rd_valid follows one cycle later (RAM read latency 1).
// Backpr. : a pop while empty is refused (no RAM read) and is flagged/counted as underflow.
//
// Ports:
//   clk, rst       sole clock, synchronous active-high reset
//   pop            consumer read request, one request per active cycle
//   wr_ptr         write pointer (ADDR_WIDTH+1 bits, MSB = wrap bit) from the write side
//   rd_en/rd_addr  RAM read port controls
//   rd_ptr         registered read pointer, returned to the write side for its full flag
//   empty, almost_empty, level   fill status, combinational from both pointers
//   rd_valid       RAM output data valid this cycle
//   underflow      one-cycle pulse after a refused pop; underflow_cnt saturates at 255
module fifo_read_control #(
  parameter int ADDR_WIDTH         = 4,
  parameter int ALMOST_EMPTY_LEVEL = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pop,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  rd_valid,
  output logic                  underflow,
  output logic [7:0]            underflow_cnt
);

  localparam logic [ADDR_WIDTH:0] AE_LEVEL = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_LEVEL);
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH + 1)'(1);

  logic refuse;

  always_comb begin
    // Full-width compare: equal lower bits with differing wrap bits means full, not empty.
    empty        = (rd_ptr == wr_ptr);
    // Modulo subtraction gives 0..2^ADDR_WIDTH for any legal pointer pair.
    level        = wr_ptr - rd_ptr;
    almost_empty = (level <= AE_LEVEL);
    // Reset blocks the RAM read so a read in the reset cycle never produces rd_valid.
    rd_en        = pop & ~empty & ~rst;
    rd_addr      = rd_ptr[ADDR_WIDTH-1:0];
    refuse       = pop & empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr        <= '0;
      rd_valid      <= 1'b0;
      underflow     <= 1'b0;
      underflow_cnt <= 8'd0;
    end else begin
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      rd_valid  <= rd_en;
      underflow <= refuse;
      if (refuse && (underflow_cnt != 8'hFF)) begin
        underflow_cnt <= underflow_cnt + 8'd1;
      end
    end
  end

endmodule
